led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
//
// PURPOSE
//   Parametrised LED pattern generator; next-generation LED counter.
//   A prescaler divides in_clk into pattern ticks.
//   Each tick advances one of four runtime-selectable patterns: binary, Gray, bouncing scanner, fill/empty bar.
//   Sits between board clock/reset and the LED pins. Also exports tick and wrap strobes for other status logic.
//
// PARAMETERS
//   LED_WIDTH   6        number of LEDs driven; legal range 1..32
//   WAIT_TIME   1048576  in_clk cycles per pattern tick; legal >= 1
//   ACTIVE_LOW  1        1: out_led bits inverted (0 = lit); 0: 1 = lit
//
// PORTS
//   in_clk         in   1          sole clock, rising edge
//   in_rst         in   1          synchronous reset, active-high
//   in_enable      in   1          1: prescaler runs; 0: prescaler and pattern hold
//   in_mode        in   2          00 binary, 01 Gray, 10 scanner, 11 bar
//   in_dir         in   1          binary/Gray only: 0 count up, 1 count down
//   out_led        out  LED_WIDTH  registered pattern, polarity per ACTIVE_LOW
//   out_tick       out  1          1-cycle pulse, cycle the new pattern appears
//   out_wrap       out  1          1-cycle pulse, pattern returned to start point
//
// BEHAVIOUR
//   - Reset values:
//     - out_led all LEDs off (all ones if ACTIVE_LOW), out_tick = out_wrap = 0.
//     - prescaler = 0, count = 0, scan_pos = 0, scan_dir = up, bar_level = 0, bar_phase = FILL, mode_q = 00.
//   - Prescaler counts 0..WAIT_TIME-1 while in_enable = 1, then wraps to 0.
//     - tick = (prescaler == WAIT_TIME-1) && in_enable.
//     - With WAIT_TIME = 1, tick fires every enabled cycle.
//   - Latency: tick in cycle N -> state updates at end of N.
//     - out_led shows the new pattern from N+1; out_tick (and out_wrap if due) high in N+1 only.
//     - All outputs are registers; none are combinational from inputs.
//   - Binary (00): LED_WIDTH-bit count, +1 or -1 per tick, modulo 2^LED_WIDTH.
//     - out_wrap when up moves all-ones->0, or down moves 0->all-ones.
//   - Gray (01): same counter and wrap rule; pattern = count ^ (count >> 1).
//   - Scanner (10): pattern = 1 << scan_pos. States UP/DOWN.
//     - UP: pos+1; at LED_WIDTH-1 switch to DOWN.
//     - DOWN: pos-1; at 0 switch to UP.
//     - The endpoint LED shows for exactly one tick per visit.
//     - out_wrap on the tick that moves pos to 0.
//     - LED_WIDTH = 1: pos stays 0 and out_wrap fires every tick.
//   - Bar (11): pattern = (1 << level) - 1; level range 0..LED_WIDTH. States FILL/EMPTY.
//     - FILL: level+1; at LED_WIDTH switch to EMPTY.
//     - EMPTY: level-1; at 0 switch to FILL.
//     - out_wrap on the tick that returns level to 0.
//   - in_dir is ignored in scanner and bar modes.
//     - A change of in_dir in binary/Gray applies from the next tick; no reload.
//   - Mode change: when in_mode != mode_q, mode_q <= in_mode and the prescaler is cleared.
//     - All pattern state reloads to its reset values.
//     - The new mode's initial pattern shows the next cycle, with no tick or wrap.
//     - Mode change beats a coincident tick.
//     - Mode change is honoured even when in_enable = 0.
//   - in_enable = 0: prescaler, pattern and out_led hold; out_tick = out_wrap = 0.
//     - Re-enabling resumes from the held prescaler value.
//   - in_rst mid-operation: next cycle all state and outputs take reset values; no strobes.
//   - Widths: prescaler is $clog2(WAIT_TIME+1) bits; level is $clog2(LED_WIDTH+1) bits; no truncation.
//
// CONFIGURATION
//   - LED_PWM_EN defined: adds port in_brightness (in, 4 bits), registered once internally.
//     - A free-running 4-bit pwm_cnt (reset 0) gates the pattern.
//     - An LED is lit only when pattern bit = 1 and pwm_cnt < brightness.
//     - 0 = all off; 15 = lit 15 of 16 cycles.
//     - Tick, wrap and pattern timing are unchanged.
//   - LED_PWM_EN undefined: port absent; pattern bits drive out_led directly (full brightness).
//
// TESTING  (LED_WIDTH=4, WAIT_TIME=4, ACTIVE_LOW=0 unless stated)
//   - Reset, mode 00, dir 0, enable 1 -> out_led 0,1,2,... one step per 4 cycles.
//     - After 16 ticks out_led = 0 with out_wrap = 1 for exactly one cycle.
//   - Mode 00, dir 1 from reset -> first tick gives 4'hF with out_wrap = 1, then 4'hE.
//     - Mode 01, dir 0 -> 0000,0001,0011,0010,0110.
//   - Mode 10 -> 0001,0010,0100,1000,0100,0010,0001; out_wrap only on the final 0001.
//     - Mode 11 -> 0000,0001,0011,0111,1111,0111,0011,0001,0000; out_wrap on final 0000.
//   - Mode switch 00->10 at count 5, coincident with tick -> next cycle 0001, no strobes, prescaler 0.
//     - Enable low 10 cycles -> out_led frozen, no strobes.
//     - in_rst mid-run -> out_led 0 the next cycle.
//   - ACTIVE_LOW=1 -> reset shows 4'hF. With LED_PWM_EN and brightness 8: lit LEDs on 8 of every 16 cycles.
//     - brightness 0 -> out_led constantly off.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// Prescaled LED pattern generator: binary, Gray, bouncing scanner and fill/empty bar.
// Optional PWM brightness gating when LED_PWM_EN is defined.
module led_pattern_sequencer #(
    parameter int LED_WIDTH  = 6,
    parameter int WAIT_TIME  = 1048576,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_enable,
    input  logic [1:0]           in_mode,
    input  logic                 in_dir,
`ifdef LED_PWM_EN
    input  logic [3:0]           in_brightness,
`endif
    output logic [LED_WIDTH-1:0] out_led,
    output logic                 out_tick,
    output logic                 out_wrap
);

    localparam int unsigned PW = $clog2(WAIT_TIME + 1);
    localparam int unsigned LW = $clog2(LED_WIDTH + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(WAIT_TIME - 1);
    localparam logic [LW-1:0] POS_LAST = LW'(LED_WIDTH - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(LED_WIDTH);
    localparam logic [LW-1:0] LW_ONE   = LW'(1);
    localparam logic [LED_WIDTH-1:0] LED_ONE = LED_WIDTH'(1);
    localparam logic [LED_WIDTH-1:0] LED_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic { SCAN_UP, SCAN_DOWN } scan_dir_t;
    typedef enum logic { BAR_FILL, BAR_EMPTY } bar_phase_t;

    logic [PW-1:0]        pre_q, pre_d;
    logic [LED_WIDTH-1:0] cnt_q, cnt_d;
    logic [LW-1:0]        pos_q, pos_d;
    logic [LW-1:0]        lvl_q, lvl_d;
    scan_dir_t            sdir_q, sdir_d;
    bar_phase_t           phase_q, phase_d;
    logic [1:0]           mode_q, mode_d;
    logic                 tick, tick_d, wrap_d;
    logic [LED_WIDTH-1:0] pat, lit, led_d;

    function automatic logic [LED_WIDTH-1:0] pattern_of(
        input logic [1:0]           m,
        input logic [LED_WIDTH-1:0] c,
        input logic [LW-1:0]        p,
        input logic [LW-1:0]        l
    );
        logic [LED_WIDTH-1:0] r;
        case (m)
            2'b00:   r = c;
            2'b01:   r = c ^ (c >> 1);
            2'b10:   r = LED_ONE << p;
            default: r = ~({LED_WIDTH{1'b1}} << l);
        endcase
        return r;
    endfunction

    always_comb begin
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        lvl_d   = lvl_q;
        sdir_d  = sdir_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        tick    = in_enable && (pre_q == PRE_LAST);

        // A mode change reloads all pattern state and swallows any coincident tick.
        if (in_mode != mode_q) begin
            mode_d  = in_mode;
            pre_d   = '0;
            cnt_d   = '0;
            pos_d   = '0;
            lvl_d   = '0;
            sdir_d  = SCAN_UP;
            phase_d = BAR_FILL;
        end else if (in_enable) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                tick_d = 1'b1;
                case (mode_q)
                    2'b00, 2'b01: begin
                        if (in_dir) begin
                            cnt_d  = cnt_q - 1'b1;
                            wrap_d = (cnt_q == '0);
                        end else begin
                            cnt_d  = cnt_q + 1'b1;
                            wrap_d = (cnt_q == '1);
                        end
                    end
                    2'b10: begin
                        if (LED_WIDTH == 1) begin
                            wrap_d = 1'b1;
                        end else if (sdir_q == SCAN_UP) begin
                            pos_d = pos_q + 1'b1;
                            if (pos_q + 1'b1 == POS_LAST) sdir_d = SCAN_DOWN;
                        end else begin
                            pos_d = pos_q - 1'b1;
                            if (pos_q == LW_ONE) begin
                                sdir_d = SCAN_UP;
                                wrap_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (phase_q == BAR_FILL) begin
                            lvl_d = lvl_q + 1'b1;
                            if (lvl_q + 1'b1 == LVL_FULL) phase_d = BAR_EMPTY;
                        end else begin
                            lvl_d = lvl_q - 1'b1;
                            if (lvl_q == LW_ONE) begin
                                phase_d = BAR_FILL;
                                wrap_d  = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt_q;
    logic [3:0] bright_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            pwm_cnt_q <= '0;
            bright_q  <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            bright_q  <= in_brightness;
        end
    end
`endif

    always_comb begin
        pat = pattern_of(mode_d, cnt_d, pos_d, lvl_d);
`ifdef LED_PWM_EN
        lit = pat & {LED_WIDTH{pwm_cnt_q < bright_q}};
`else
        lit = pat;
`endif
        led_d = (ACTIVE_LOW != 0) ? ~lit : lit;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            pre_q    <= '0;
            cnt_q    <= '0;
            pos_q    <= '0;
            lvl_q    <= '0;
            sdir_q   <= SCAN_UP;
            phase_q  <= BAR_FILL;
            mode_q   <= 2'b00;
            out_led  <= LED_OFF;
            out_tick <= 1'b0;
            out_wrap <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            lvl_q    <= lvl_d;
            sdir_q   <= sdir_d;
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            out_led  <= led_d;
            out_tick <= tick_d;
            out_wrap <= wrap_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer (LED_WIDTH=4, WAIT_TIME=4, ACTIVE_LOW=0).
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       dir;
    logic [3:0] out_led;
    logic       out_tick;
    logic       out_wrap;

    int total = 0;
    int bad   = 0;
    logic [4:0] sb[$];

    led_pattern_sequencer #(
        .LED_WIDTH (4),
        .WAIT_TIME (4),
        .ACTIVE_LOW(0)
    ) dut (
        .in_clk   (clk),
        .in_rst   (rst),
        .in_enable(en),
        .in_mode  (mode),
        .in_dir   (dir),
        .out_led  (out_led),
        .out_tick (out_tick),
        .out_wrap (out_wrap)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] led, input logic wrap);
        sb.push_back({led, wrap});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every tick strobe pops one expected {led, wrap} entry.
    always @(negedge clk) begin
        logic [4:0] e;
        if (out_wrap && !out_tick) begin
            total++;
            bad++;
            $display("FAIL wrap_without_tick: got wrap=1 tick=0 expected wrap=0");
        end
        if (out_tick) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tick: got led=%h wrap=%b expected no tick", out_led, out_wrap);
            end else begin
                e = sb.pop_front();
                if ({out_led, out_wrap} !== e) begin
                    bad++;
                    $display("FAIL tick_pattern: got led=%h wrap=%b expected led=%h wrap=%b",
                             out_led, out_wrap, e[4:1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [3:0] gray_exp[4];
        logic [3:0] scan_exp[6];
        logic [3:0] bar_exp[8];
        gray_exp = '{4'h1, 4'h3, 4'h2, 4'h6};
        scan_exp = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};
        bar_exp  = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};

        rst = 1'b1; en = 1'b1; mode = 2'b00; dir = 1'b0;
        step(2);
        chk("reset_led", 32'(out_led), 32'h0);
        chk("reset_tick", 32'(out_tick), 32'h0);
        chk("reset_wrap", 32'(out_wrap), 32'h0);

        // Binary up: 16 ticks, last one wraps to 0.
        for (int i = 1; i <= 16; i++) push(4'(i), i == 16);
        rst = 1'b0;
        step(64);

        // Enable low: frozen output, no strobes.
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("freeze_led", 32'(out_led), 32'h0);
            chk("freeze_tick", 32'(out_tick), 32'h0);
        end

        // Resume from held prescaler (0): next tick after 4 cycles.
        en = 1'b1;
        push(4'h1, 1'b0);
        step(4);

        // Direction flip without reload: 1 -> 0 -> F(wrap) -> E.
        dir = 1'b1;
        push(4'h0, 1'b0);
        push(4'hF, 1'b1);
        push(4'hE, 1'b0);
        step(12);

        // Mid-run reset.
        rst = 1'b1;
        step(1);
        chk("midrun_rst_led", 32'(out_led), 32'h0);
        chk("midrun_rst_tick", 32'(out_tick), 32'h0);
        chk("midrun_rst_wrap", 32'(out_wrap), 32'h0);

        // Down count from reset: F with wrap, then E.
        rst = 1'b0;
        push(4'hF, 1'b1);
        push(4'hE, 1'b0);
        step(8);

        // Gray up.
        mode = 2'b01; dir = 1'b0;
        step(1);
        chk("gray_init_led", 32'(out_led), 32'h0);
        chk("gray_init_tick", 32'(out_tick), 32'h0);
        foreach (gray_exp[i]) push(gray_exp[i], 1'b0);
        step(16);

        // Scanner: wrap only on return to LED 0.
        mode = 2'b10;
        step(1);
        chk("scan_init_led", 32'(out_led), 32'h1);
        chk("scan_init_tick", 32'(out_tick), 32'h0);
        foreach (scan_exp[i]) push(scan_exp[i], i == 5);
        step(24);

        // Bar fill/empty: wrap only on return to empty.
        mode = 2'b11;
        step(1);
        chk("bar_init_led", 32'(out_led), 32'h0);
        foreach (bar_exp[i]) push(bar_exp[i], i == 7);
        step(32);

        // Mode switch coincident with a tick at count 5.
        mode = 2'b00;
        step(1);
        chk("bin_init_led", 32'(out_led), 32'h0);
        for (int i = 1; i <= 5; i++) push(4'(i), 1'b0);
        step(20);
        step(3);
        mode = 2'b10;
        step(1);
        chk("switch_led", 32'(out_led), 32'h1);
        chk("switch_tick", 32'(out_tick), 32'h0);
        chk("switch_wrap", 32'(out_wrap), 32'h0);
        push(4'h2, 1'b0);
        step(3);
        chk("switch_pre_cleared_no_tick", 32'(out_tick), 32'h0);
        step(1);
        chk("switch_pre_cleared_tick", 32'(out_tick), 32'h1);

        en = 1'b0;
        step(2);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
